// File: rtl/serial_byte_receiver.sv
// Serial-to-parallel receiver for the shift-register link: frames start on sync,
// words are assembled over WIDTH qualified bits and handed off through a one-deep
// valid/ready buffer with a sticky overrun flag.
module serial_byte_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sync,
    input  logic                       bit_valid,
    input  logic                       serial_in,
    input  logic                       data_ready,
    input  logic                       clr_overrun,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    output logic                       busy,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] fresh;
    logic             start;
    logic             advance;
    logic             last;
    logic             buf_free;

    // fresh starts a frame from a cleared register; shifted appends to the current one
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg[WIDTH-2:0], serial_in};
            fresh   = {{(WIDTH-1){1'b0}}, serial_in};
        end else begin
            shifted = {serial_in, shreg[WIDTH-1:1]};
            fresh   = {serial_in, {(WIDTH-1){1'b0}}};
        end
    end

    assign start    = bit_valid && sync;
    assign advance  = bit_valid && !sync && (state == RECV);
    assign last     = advance && (bit_count == CW'(WIDTH-1));
    // a consumer draining the buffer on this edge frees it for a completing word
    assign buf_free = !data_valid || data_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_count  <= '0;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (start) begin
                state     <= RECV;
                busy      <= 1'b1;
                shreg     <= fresh;
                bit_count <= CW'(1);
            end else if (advance) begin
                shreg <= shifted;
                if (last) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    bit_count <= '0;
                end else begin
                    bit_count <= bit_count + CW'(1);
                end
            end

            if (last && buf_free) begin
                data_out   <= shifted;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // set beats clear when both land on the same edge
            if (last && !buf_free)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Bench for serial_byte_receiver: directed scenarios plus random traffic, with an
// MSB-first and an LSB-first instance compared against a frame-level bit-queue model.
module tb_serial_byte_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sync = 1'b0, bit_valid = 1'b0, serial_in = 1'b0;
    logic       data_ready = 1'b0, clr_overrun = 1'b0;
    logic [7:0] dout0, dout1;
    logic       dv0, dv1, busy0, busy1, ovr0, ovr1;
    logic [3:0] bc0, bc1;

    int n_chk = 0;
    int n_pass = 0;

    // model state: bits of the frame in arrival order and the output buffer
    bit         mq[$];
    bit         m_busy, m_valid, m_ovr;
    logic [7:0] m_d0, m_d1;

    always #5 clk = ~clk;

    serial_byte_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .sync(sync), .bit_valid(bit_valid),
        .serial_in(serial_in), .data_ready(data_ready), .clr_overrun(clr_overrun),
        .data_out(dout0), .data_valid(dv0), .busy(busy0), .bit_count(bc0), .overrun(ovr0));

    serial_byte_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .sync(sync), .bit_valid(bit_valid),
        .serial_in(serial_in), .data_ready(data_ready), .clr_overrun(clr_overrun),
        .data_out(dout1), .data_valid(dv1), .busy(busy1), .bit_count(bc1), .overrun(ovr1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_valid = 0; m_ovr = 0;
        m_d0 = '0; m_d1 = '0;
    endtask

    task automatic model_step(input bit s, input bit b, input bit d, input bit r, input bit c);
        bit         done = 0;
        bit         set_ovr = 0;
        logic [7:0] w0 = '0, w1 = '0;
        if (b) begin
            if (s) begin
                mq.delete();
                mq.push_back(d);
                m_busy = 1;
            end else if (m_busy) begin
                mq.push_back(d);
                if (mq.size() == 8) begin
                    for (int i = 0; i < 8; i++) begin
                        w0[7-i] = mq[i];
                        w1[i]   = mq[i];
                    end
                    done = 1;
                    m_busy = 0;
                    mq.delete();
                end
            end
        end
        if (done && (!m_valid || r)) begin
            m_d0 = w0; m_d1 = w1; m_valid = 1;
        end else if (done) begin
            set_ovr = 1;
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        if (set_ovr) m_ovr = 1;
        else if (c)  m_ovr = 0;
    endtask

    task automatic check_all();
        chk("msb_data",  dout0, m_d0);
        chk("lsb_data",  dout1, m_d1);
        chk("msb_valid", dv0,   m_valid);
        chk("lsb_valid", dv1,   m_valid);
        chk("msb_busy",  busy0, m_busy);
        chk("lsb_busy",  busy1, m_busy);
        chk("msb_count", bc0,   m_busy ? mq.size() : 0);
        chk("lsb_count", bc1,   m_busy ? mq.size() : 0);
        chk("msb_ovr",   ovr0,  m_ovr);
        chk("lsb_ovr",   ovr1,  m_ovr);
    endtask

    task automatic drive(input bit s, input bit b, input bit d, input bit r, input bit c);
        @(negedge clk);
        sync = s; bit_valid = b; serial_in = d; data_ready = r; clr_overrun = c;
        @(posedge clk);
        model_step(s, b, d, r, c);
        #1;
        check_all();
    endtask

    // bits go out b7 first; rdy_last applies only on the completing bit
    task automatic send_word(input logic [7:0] w, input bit rdy_body, input bit rdy_last,
                             input int gap_after, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            drive(i == 0, 1'b1, w[7-i], (i == 7) ? rdy_last : rdy_body, 1'b0);
            if (i + 1 == gap_after)
                for (int g = 0; g < gap_len; g++) begin
                    drive(1'b0, 1'b0, 1'($urandom), rdy_body, 1'b0);
                    chk("gap_count", bc0, gap_after);
                end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data"},  {dout0, dout1}, 16'h0);
        chk({tag, "_valid"}, {dv0, dv1},     2'b0);
        chk({tag, "_busy"},  {busy0, busy1}, 2'b0);
        chk({tag, "_count"}, {bc0, bc1},     8'h0);
        chk({tag, "_ovr"},   {ovr0, ovr1},   2'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check_zero("por");
        @(negedge clk) rst_n = 1'b1;

        // basic: AA, consumer ready, valid lasts one cycle
        send_word(8'hAA, 1'b1, 1'b1, -1, 0);
        chk("aa_data", dout0, 8'hAA);
        chk("aa_valid", dv0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("aa_drop", dv0, 1'b0);

        // gapped 3C
        send_word(8'h3C, 1'b1, 1'b1, 4, 3);
        chk("gap_data", dout0, 8'h3C);

        // resync after 3 bits
        for (int i = 0; i < 3; i++) drive(i == 0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("partial_count", bc0, 3);
        send_word(8'hF0, 1'b1, 1'b1, -1, 0);
        chk("resync_data", dout0, 8'hF0);
        chk("resync_ovr", ovr0, 1'b0);

        // backpressure
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h55, 1'b0, 1'b0, -1, 0);
        send_word(8'h0F, 1'b0, 1'b0, -1, 0);
        chk("bp_data", dout0, 8'h55);
        chk("bp_ovr", ovr0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_clr", ovr0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_release", dv0, 1'b0);

        // back-to-back: pending word taken on the edge 81 completes
        send_word(8'h12, 1'b0, 1'b0, -1, 0);
        send_word(8'h81, 1'b0, 1'b1, -1, 0);
        chk("b2b_msb", dout0, 8'h81);
        chk("b2b_lsb", dout1, 8'h81);
        chk("b2b_valid", dv0, 1'b1);
        chk("b2b_ovr", ovr0, 1'b0);

        // clear-vs-set on the same edge: set wins
        send_word(8'hC3, 1'b0, 1'b0, -1, 0);
        for (int i = 0; i < 8; i++) drive(i == 0, 1'b1, 1'b1, 1'b0, i == 7);
        chk("set_wins", ovr0, 1'b1);

        // async reset mid-frame at bit_count 5
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) drive(i == 0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(8'h00, 1'b0, 1'b0, -1, 0);
        for (int i = 0; i < 5; i++) drive(i == 0, 1'b1, 1'(i), 1'b0, 1'b0);
        chk("pre_rst_count", bc0, 5);
        @(negedge clk);
        sync = 0; bit_valid = 0; serial_in = 0; data_ready = 0; clr_overrun = 0;
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // random traffic
        for (int n = 0; n < 1500; n++)
            drive($urandom_range(9) == 0, $urandom_range(3) != 0, 1'($urandom),
                  1'($urandom), $urandom_range(7) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
